// File: rtl/icache_pkg.sv
// Shared types and constants for the set-associative instruction cache.
package icache_pkg;

  typedef enum logic [1:0] {
    S_IDLE           = 2'd0,
    S_REFILL         = 2'd1,
    S_REFILL_DISCARD = 2'd2
  } state_t;

  localparam int CNT_W = 32;

endpackage

// File: rtl/icache_way.sv
// One cache way: per-set valid bit, tag and line data, with one read and one fill port.
module icache_way #(
  parameter int SETS   = 4,
  parameter int LINE_W = 128,
  parameter int TAG_W  = 26,
  parameter int IDX_W  = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_flush,
  input  logic [IDX_W-1:0]  i_rd_idx,
  output logic              o_rd_valid,
  output logic [TAG_W-1:0]  o_rd_tag,
  output logic [LINE_W-1:0] o_rd_line,
  input  logic              i_wr_en,
  input  logic [IDX_W-1:0]  i_wr_idx,
  input  logic [TAG_W-1:0]  i_wr_tag,
  input  logic [LINE_W-1:0] i_wr_line
);

  logic [SETS-1:0]   r_valid;
  logic [TAG_W-1:0]  r_tag  [SETS];
  logic [LINE_W-1:0] r_data [SETS];

  // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       r_valid <= '0;
    else if (i_flush) r_valid <= '0;
    else if (i_wr_en) r_valid[i_wr_idx] <= 1'b1;
  end

  // NOTE: tag/data arrays carry no reset; the valid bit alone qualifies their contents.
  always_ff @(posedge clk) begin
    if (i_wr_en) begin
      r_tag[i_wr_idx]  <= i_wr_tag;
      r_data[i_wr_idx] <= i_wr_line;
    end
  end

  assign o_rd_valid = r_valid[i_rd_idx];
  assign o_rd_tag   = r_tag[i_rd_idx];
  assign o_rd_line  = r_data[i_rd_idx];

endmodule

// File: rtl/instr_cache_sa.sv
// Set-associative instruction cache with combinational lookup and a single outstanding line refill.
module instr_cache_sa
  import icache_pkg::*;
#(
  parameter int SETS       = 4,
  parameter int WAYS       = 2,
  parameter int LINE_BYTES = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    flush,
  input  logic                    mem_read,
  input  logic [31:0]             address,
  output logic [31:0]             readdata,
  output logic                    cache_hit,
  output logic                    fetch,
  output logic                    reqI_mem,
  output logic [31:0]             reqAddrI_mem,
  input  logic [8*LINE_BYTES-1:0] data_from_mem,
  input  logic                    read_ready_from_mem,
  output logic [31:0]             hit_cnt,
  output logic [31:0]             miss_cnt
);

  localparam int LINE_W = 8 * LINE_BYTES;
  localparam int OFF_W  = $clog2(LINE_BYTES);
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = 32 - OFF_W - IDX_W;

  state_t           r_state;
  logic             r_req;
  logic [31:0]      r_req_addr;
  logic [CNT_W-1:0] r_hit_cnt;
  logic [CNT_W-1:0] r_miss_cnt;

  logic [TAG_W-1:0]  w_tag, w_fill_tag;
  logic [IDX_W-1:0]  w_idx, w_fill_idx, w_rd_idx;
  logic [OFF_W-1:0]  w_off;
  logic [OFF_W+4:0]  w_shamt;
  logic [WAYS-1:0]   w_way_valid, w_way_hit, w_way_we;
  logic [TAG_W-1:0]  w_way_tag  [WAYS];
  logic [LINE_W-1:0] w_way_line [WAYS];
  logic [LINE_W-1:0] w_hit_line, w_shifted;
  logic              w_lookup_hit, w_miss, w_fill, w_victim;

  assign w_tag      = address[31 -: TAG_W];
  assign w_idx      = address[OFF_W +: IDX_W];
  assign w_off      = address[OFF_W-1:0];
  // The latched request address is the single source of the fill target.
  assign w_fill_tag = r_req_addr[31 -: TAG_W];
  assign w_fill_idx = r_req_addr[OFF_W +: IDX_W];
  assign w_rd_idx   = (r_state == S_IDLE) ? w_idx : w_fill_idx;

  for (genvar g = 0; g < WAYS; g++) begin : g_way
    icache_way #(
      .SETS(SETS), .LINE_W(LINE_W), .TAG_W(TAG_W), .IDX_W(IDX_W)
    ) u_way (
      .clk       (clk),
      .reset     (reset),
      .i_flush   (flush),
      .i_rd_idx  (w_rd_idx),
      .o_rd_valid(w_way_valid[g]),
      .o_rd_tag  (w_way_tag[g]),
      .o_rd_line (w_way_line[g]),
      .i_wr_en   (w_way_we[g]),
      .i_wr_idx  (w_fill_idx),
      .i_wr_tag  (w_fill_tag),
      .i_wr_line (data_from_mem)
    );
    assign w_way_hit[g] = w_way_valid[g] && (w_way_tag[g] == w_tag);
    assign w_way_we[g]  = w_fill && (w_victim == 1'(g));
  end

  assign w_lookup_hit = (r_state == S_IDLE) && (|w_way_hit);
  assign w_miss       = (r_state == S_IDLE) && mem_read && !flush && !w_lookup_hit;
  assign w_fill       = (r_state == S_REFILL) && read_ready_from_mem && !flush;

  assign cache_hit = reset && mem_read && !flush && w_lookup_hit;
  assign fetch     = !reset || ((r_state == S_IDLE) && !flush && (!mem_read || w_lookup_hit));

  // NOTE: every always_comb target gets a default first so no latch is inferred.
  always_comb begin
    w_hit_line = '0;
    for (int w = 0; w < WAYS; w++) begin
      if (w_way_hit[w]) w_hit_line = w_hit_line | w_way_line[w];
    end
  end

  assign w_shamt   = {w_off >> 2, 5'b00000};
  assign w_shifted = w_hit_line >> w_shamt;
  assign readdata  = cache_hit ? w_shifted[31:0] : 32'h0;

  if (WAYS == 2) begin : g_lru
    logic [SETS-1:0] r_lru;  // way to evict next in each set

    assign w_victim = !w_way_valid[0] ? 1'b0 :
                      !w_way_valid[1] ? 1'b1 : r_lru[w_fill_idx];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset)         r_lru <= '0;
      else if (w_fill)    r_lru[w_fill_idx] <= ~w_victim;
      else if (cache_hit) r_lru[w_idx] <= w_way_hit[0];
    end
  end else begin : g_direct
    assign w_victim = 1'b0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_req      <= 1'b0;
      r_req_addr <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (w_miss) begin
          r_state    <= S_REFILL;
          r_req      <= 1'b1;
          r_req_addr <= {w_tag, w_idx, {OFF_W{1'b0}}};
        end
        S_REFILL: if (read_ready_from_mem) begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
        end else if (flush) begin
          r_state <= S_REFILL_DISCARD;
        end
        S_REFILL_DISCARD: if (read_ready_from_mem) begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
        end
        default: begin
          r_state <= S_IDLE;
          r_req   <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_hit_cnt  <= '0;
      r_miss_cnt <= '0;
    end else begin
      if (cache_hit && (r_hit_cnt != '1)) r_hit_cnt  <= r_hit_cnt + 1'b1;
      if (w_miss && (r_miss_cnt != '1))   r_miss_cnt <= r_miss_cnt + 1'b1;
    end
  end

  assign reqI_mem     = r_req;
  assign reqAddrI_mem = r_req_addr;
  assign hit_cnt      = r_hit_cnt;
  assign miss_cnt     = r_miss_cnt;

endmodule

// File: tb/tb_instr_cache_sa.sv
// Directed bench for instr_cache_sa (SETS=4, WAYS=2, LINE_BYTES=16) with hand-computed expectations.
module tb_instr_cache_sa;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         flush = 1'b0;
  logic         mem_read = 1'b0;
  logic [31:0]  address = '0;
  logic [31:0]  readdata;
  logic         cache_hit;
  logic         fetch;
  logic         reqI_mem;
  logic [31:0]  reqAddrI_mem;
  logic [127:0] data_from_mem = '0;
  logic         read_ready_from_mem = 1'b0;
  logic [31:0]  hit_cnt;
  logic [31:0]  miss_cnt;

  int n_checks = 0;
  int n_errors = 0;

  instr_cache_sa #(.SETS(4), .WAYS(2), .LINE_BYTES(16)) dut (
    .clk                (clk),
    .reset              (reset),
    .flush              (flush),
    .mem_read           (mem_read),
    .address            (address),
    .readdata           (readdata),
    .cache_hit          (cache_hit),
    .fetch              (fetch),
    .reqI_mem           (reqI_mem),
    .reqAddrI_mem       (reqAddrI_mem),
    .data_from_mem      (data_from_mem),
    .read_ready_from_mem(read_ready_from_mem),
    .hit_cnt            (hit_cnt),
    .miss_cnt           (miss_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected normal completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [127:0] mk_line(input logic [31:0] w0, w1, w2, w3);
    return {w3, w2, w1, w0};
  endfunction

  // Inputs change 1 time unit after the rising edge; outputs are compared 1 unit later.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // Miss on a, then return line in the following REFILL cycle; ends in IDLE.
  task automatic fill(input logic [31:0] a, input logic [127:0] line);
    mem_read = 1'b1; address = a;
    cyc();
    mem_read = 1'b0; data_from_mem = line; read_ready_from_mem = 1'b1;
    cyc();
    read_ready_from_mem = 1'b0;
  endtask

  task automatic flush_all();
    mem_read = 1'b0; flush = 1'b1;
    cyc();
    flush = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; mem_read = 1'b1; address = 32'h100;
    cyc(); #1;
    n_checks++; if (fetch !== 1'b1) begin n_errors++; $display("FAIL rst_fetch: got %0b want 1", fetch); end
    n_checks++; if (cache_hit !== 1'b0) begin n_errors++; $display("FAIL rst_hit: got %0b want 0", cache_hit); end
    n_checks++; if (readdata !== 32'h0) begin n_errors++; $display("FAIL rst_rdata: got %h want 0", readdata); end
    n_checks++; if (reqI_mem !== 1'b0) begin n_errors++; $display("FAIL rst_req: got %0b want 0", reqI_mem); end
    n_checks++; if ({hit_cnt, miss_cnt} !== 64'h0) begin n_errors++; $display("FAIL rst_cnt: got %h/%h want 0/0", hit_cnt, miss_cnt); end
    mem_read = 1'b0;
    cyc();
    reset = 1'b1;
    cyc();
  endtask

  task automatic test_cold_miss();
    mem_read = 1'b1; address = 32'h100;
    #1;
    n_checks++; if (fetch !== 1'b0) begin n_errors++; $display("FAIL cold_stall: fetch got %0b want 0", fetch); end
    n_checks++; if (cache_hit !== 1'b0) begin n_errors++; $display("FAIL cold_nohit: got %0b want 0", cache_hit); end
    cyc();
    address = 32'h1F0;  // address wanders during the refill
    #1;
    n_checks++; if (reqI_mem !== 1'b1) begin n_errors++; $display("FAIL cold_req: got %0b want 1", reqI_mem); end
    n_checks++; if (reqAddrI_mem !== 32'h100) begin n_errors++; $display("FAIL cold_addr: got %h want 00000100", reqAddrI_mem); end
    n_checks++; if (fetch !== 1'b0 || cache_hit !== 1'b0) begin n_errors++; $display("FAIL cold_refill_out: fetch %0b hit %0b want 0 0", fetch, cache_hit); end
    cyc();
    n_checks++; if (reqI_mem !== 1'b1 || reqAddrI_mem !== 32'h100) begin n_errors++; $display("FAIL cold_hold: req %0b addr %h want 1 00000100", reqI_mem, reqAddrI_mem); end
    data_from_mem = mk_line(32'h11110000, 32'hDEADBEEF, 32'h22222222, 32'h33333333);
    read_ready_from_mem = 1'b1; address = 32'h104;
    cyc();
    read_ready_from_mem = 1'b0;
    #1;
    n_checks++; if (cache_hit !== 1'b1 || readdata !== 32'hDEADBEEF) begin n_errors++; $display("FAIL cold_hit: hit %0b data %h want 1 deadbeef", cache_hit, readdata); end
    n_checks++; if (fetch !== 1'b1 || reqI_mem !== 1'b0) begin n_errors++; $display("FAIL cold_fetch: fetch %0b req %0b want 1 0", fetch, reqI_mem); end
    cyc();
    mem_read = 1'b0;
    #1;
    n_checks++; if (hit_cnt !== 32'd1 || miss_cnt !== 32'd1) begin n_errors++; $display("FAIL cold_cnt: hit %0d miss %0d want 1 1", hit_cnt, miss_cnt); end
    mem_read = 1'b1; address = 32'h10C;
    #1;
    n_checks++; if (readdata !== 32'h33333333) begin n_errors++; $display("FAIL word3: got %h want 33333333", readdata); end
    mem_read = 1'b0;
    #1;
    n_checks++; if (fetch !== 1'b1 || cache_hit !== 1'b0 || readdata !== 32'h0) begin n_errors++; $display("FAIL idle_noread: fetch %0b hit %0b data %h want 1 0 0", fetch, cache_hit, readdata); end
    cyc();
  endtask

  task automatic test_flush_idle();
    mem_read = 1'b1; address = 32'h100; flush = 1'b1;
    #1;
    n_checks++; if (cache_hit !== 1'b0 || fetch !== 1'b0) begin n_errors++; $display("FAIL flush_cycle: hit %0b fetch %0b want 0 0", cache_hit, fetch); end
    cyc();
    flush = 1'b0;
    #1;
    n_checks++; if (cache_hit !== 1'b0 || fetch !== 1'b0) begin n_errors++; $display("FAIL flush_miss: hit %0b fetch %0b want 0 0", cache_hit, fetch); end
    cyc();
    mem_read = 1'b0;
    #1;
    n_checks++; if (reqI_mem !== 1'b1 || reqAddrI_mem !== 32'h100) begin n_errors++; $display("FAIL flush_req: req %0b addr %h want 1 00000100", reqI_mem, reqAddrI_mem); end
    read_ready_from_mem = 1'b1;
    cyc();
    read_ready_from_mem = 1'b0;
    flush_all();
  endtask

  task automatic test_lru();
    fill(32'h000, mk_line(32'hA0, 32'hA1, 32'hA2, 32'hA3));
    fill(32'h040, mk_line(32'hB0, 32'hB1, 32'hB2, 32'hB3));
    mem_read = 1'b1; address = 32'h000;
    #1;
    n_checks++; if (cache_hit !== 1'b1 || readdata !== 32'hA0) begin n_errors++; $display("FAIL lru_hitA: hit %0b data %h want 1 000000a0", cache_hit, readdata); end
    cyc();
    fill(32'h080, mk_line(32'hC0, 32'hC1, 32'hC2, 32'hC3));
    mem_read = 1'b1; address = 32'h004;
    #1;
    n_checks++; if (cache_hit !== 1'b1 || readdata !== 32'hA1) begin n_errors++; $display("FAIL lru_keepA: hit %0b data %h want 1 000000a1", cache_hit, readdata); end
    cyc();
    address = 32'h088;
    #1;
    n_checks++; if (cache_hit !== 1'b1 || readdata !== 32'hC2) begin n_errors++; $display("FAIL lru_hitC: hit %0b data %h want 1 000000c2", cache_hit, readdata); end
    cyc();
    address = 32'h040;
    #1;
    n_checks++; if (cache_hit !== 1'b0 || fetch !== 1'b0) begin n_errors++; $display("FAIL lru_evictB: hit %0b fetch %0b want 0 0", cache_hit, fetch); end
    cyc();
    mem_read = 1'b0; read_ready_from_mem = 1'b1;
    cyc();
    read_ready_from_mem = 1'b0;
    flush_all();
  endtask

  task automatic test_flush_refill();
    mem_read = 1'b1; address = 32'h200;
    cyc();
    mem_read = 1'b0; flush = 1'b1;
    #1;
    n_checks++; if (reqI_mem !== 1'b1) begin n_errors++; $display("FAIL fr_req0: got %0b want 1", reqI_mem); end
    cyc();
    flush = 1'b0;
    cyc(); cyc();
    n_checks++; if (reqI_mem !== 1'b1 || reqAddrI_mem !== 32'h200) begin n_errors++; $display("FAIL fr_hold: req %0b addr %h want 1 00000200", reqI_mem, reqAddrI_mem); end
    data_from_mem = mk_line(32'hE0, 32'hE1, 32'hE2, 32'hE3); read_ready_from_mem = 1'b1;
    cyc();
    read_ready_from_mem = 1'b0;
    n_checks++; if (reqI_mem !== 1'b0) begin n_errors++; $display("FAIL fr_drop: got %0b want 0", reqI_mem); end
    mem_read = 1'b1; address = 32'h200;
    #1;
    n_checks++; if (cache_hit !== 1'b0 || fetch !== 1'b0) begin n_errors++; $display("FAIL fr_nowrite: hit %0b fetch %0b want 0 0", cache_hit, fetch); end
    cyc();
    mem_read = 1'b0; read_ready_from_mem = 1'b1;
    cyc();
    read_ready_from_mem = 1'b0;
    flush_all();
  endtask

  task automatic test_flush_and_ready();
    mem_read = 1'b1; address = 32'h300;
    cyc();
    mem_read = 1'b0; flush = 1'b1; read_ready_from_mem = 1'b1;
    data_from_mem = mk_line(32'hF0, 32'hF1, 32'hF2, 32'hF3);
    cyc();
    flush = 1'b0; read_ready_from_mem = 1'b0;
    #1;
    n_checks++; if (reqI_mem !== 1'b0) begin n_errors++; $display("FAIL fa_idle: req %0b want 0", reqI_mem); end
    mem_read = 1'b1; address = 32'h300;
    #1;
    n_checks++; if (cache_hit !== 1'b0 || fetch !== 1'b0) begin n_errors++; $display("FAIL fa_nowrite: hit %0b fetch %0b want 0 0", cache_hit, fetch); end
    cyc();
    mem_read = 1'b0; read_ready_from_mem = 1'b1;
    cyc();
    read_ready_from_mem = 1'b0;
  endtask

  task automatic test_reset_mid_refill();
    fill(32'h000, mk_line(32'h50, 32'h51, 32'h52, 32'h53));
    mem_read = 1'b1; address = 32'h040;
    cyc();
    mem_read = 1'b0;
    n_checks++; if (reqI_mem !== 1'b1) begin n_errors++; $display("FAIL rm_req: got %0b want 1", reqI_mem); end
    reset = 1'b0;
    #1;
    n_checks++; if (reqI_mem !== 1'b0 || reqAddrI_mem !== 32'h0) begin n_errors++; $display("FAIL rm_drop: req %0b addr %h want 0 0", reqI_mem, reqAddrI_mem); end
    n_checks++; if (hit_cnt !== 32'h0 || miss_cnt !== 32'h0) begin n_errors++; $display("FAIL rm_cnt: hit %0d miss %0d want 0 0", hit_cnt, miss_cnt); end
    cyc();
    reset = 1'b1;
    data_from_mem = mk_line(32'h60, 32'h61, 32'h62, 32'h63); read_ready_from_mem = 1'b1;
    cyc();
    read_ready_from_mem = 1'b0;
    n_checks++; if (reqI_mem !== 1'b0) begin n_errors++; $display("FAIL rm_stray: req %0b want 0", reqI_mem); end
    mem_read = 1'b1; address = 32'h000;
    #1;
    n_checks++; if (cache_hit !== 1'b0 || fetch !== 1'b0) begin n_errors++; $display("FAIL rm_valid_clr: hit %0b fetch %0b want 0 0", cache_hit, fetch); end
    cyc();
    mem_read = 1'b0;
    n_checks++; if (miss_cnt !== 32'd1 || reqAddrI_mem !== 32'h000 || reqI_mem !== 1'b1) begin n_errors++; $display("FAIL rm_remiss: miss %0d req %0b addr %h want 1 1 0", miss_cnt, reqI_mem, reqAddrI_mem); end
    read_ready_from_mem = 1'b1;
    cyc();
    read_ready_from_mem = 1'b0;
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_flush_idle();
    test_lru();
    test_flush_refill();
    test_flush_and_ready();
    test_reset_mid_refill();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instr_cache_sa.md
INSTR_CACHE_SA -- requirements
Module: instr_cache_sa

Interface
REQ-001 Parameter SETS, default 4, number of sets; SHALL be a power of two, >= 2.
REQ-002 Parameter WAYS, default 2, associativity; SHALL be 1 or 2.
REQ-003 Parameter LINE_BYTES, default 16, line size; SHALL be a power of two, >= 4; LINE_W = 8*LINE_BYTES.
REQ-004 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 flush  input  1  invalidate all lines.
REQ-007 mem_read  input  1  fetch request this cycle.
REQ-008 address  input  32  byte address of the fetch; bits [1:0] SHALL be ignored.
REQ-009 readdata  output  32  fetched instruction word.
REQ-010 cache_hit  output  1  readdata valid this cycle.
REQ-011 fetch  output  1  high = pipeline may advance; low = stall.
REQ-012 reqI_mem  output  1  line refill request to memory.
REQ-013 reqAddrI_mem  output  32  line-aligned refill address.
REQ-014 data_from_mem  input  LINE_W  refill line data; byte 0 in bits [7:0].
REQ-015 read_ready_from_mem  input  1  one-cycle pulse; data_from_mem valid.
REQ-016 hit_cnt, miss_cnt  output  32 each  performance counters.

Function
REQ-017 Address split: offset = log2(LINE_BYTES) LSBs; index = next log2(SETS) bits; tag = remaining MSBs.
REQ-018 FSM states: IDLE, REFILL, REFILL_DISCARD.
REQ-019 Lookup in IDLE SHALL be combinational; hit = valid and tag match in any way of the indexed set.
REQ-020 In IDLE with mem_read and hit, cache_hit=1, readdata = the addressed word, fetch=1, all in the same cycle.
REQ-021 When cache_hit=0, readdata SHALL be 0.
REQ-022 In IDLE without mem_read, fetch=1 and cache_hit=0.
REQ-023 IDLE, mem_read, miss: latch index and tag, go to REFILL next cycle, fetch=0 in the miss cycle.
REQ-024 In REFILL and REFILL_DISCARD, reqI_mem=1, reqAddrI_mem = {latched tag, latched index, offset zeros}, fetch=0, cache_hit=0.
REQ-025 reqI_mem SHALL stay high until read_ready_from_mem is sampled high; the address SHALL be stable meanwhile.
REQ-026 Refill from REFILL on read_ready_from_mem:
- write data, tag and valid=1 into the victim way;
- update LRU;
- return to IDLE;
- the retried access hits on the next cycle.
REQ-027 Victim selection (WAYS=2): an invalid way first, way 0 before way 1; else the LRU way.
REQ-028 LRU update (WAYS=2): one bit per set; every hit and every fill SHALL mark the accessed way most-recently-used.
REQ-029 Victim selection (WAYS=1): always way 0; no LRU state.
REQ-030 Changes on address during REFILL SHALL NOT affect the fill target.
REQ-031 Flush, all states: clear all valid bits at the next edge.
REQ-032 Flush in IDLE: cache_hit=0 and fetch=0 that cycle.
REQ-033 Flush in REFILL: go to REFILL_DISCARD, or to IDLE without writing if read_ready_from_mem is high in the same cycle; flush wins.
REQ-034 In REFILL_DISCARD, read_ready_from_mem SHALL return to IDLE without writing any array.
REQ-035 hit_cnt SHALL increment on each cache_hit cycle; miss_cnt on each IDLE-to-REFILL transition; both saturate at 0xFFFFFFFF.

Reset
REQ-036 Reset SHALL asynchronously clear:
- state to IDLE;
- all valid bits and LRU bits;
- reqI_mem, reqAddrI_mem, hit_cnt and miss_cnt to 0.
REQ-037 During reset, cache_hit=0, readdata=0 and fetch=1.
REQ-038 Reset asserted mid-refill SHALL drop reqI_mem immediately; a later read_ready_from_mem SHALL be ignored.
REQ-039 Data and tag arrays need no reset.

Structure
REQ-040 Package icache_pkg SHALL hold the FSM state enum and the counter width constant.
REQ-041 Sub-module icache_way SHALL hold one way's data, tag and valid arrays, with a read port and a write/fill port; it SHALL be instantiated WAYS times.
REQ-042 Tag width, index width and offset width SHALL be derived localparams.

Verification (SETS=4, WAYS=2, LINE_BYTES=16)
REQ-043 Cold miss: reset, then read 0x100.
- Expected: fetch=0, then reqI_mem=1 with reqAddrI_mem=0x100.
- Return a line with word1=0xDEADBEEF; read 0x104.
- Expected: cache_hit=1 and readdata=0xDEADBEEF the cycle after the fill, hit_cnt=1, miss_cnt=1.
REQ-044 LRU: fill 0x000 and 0x040 (set 0), hit 0x000, then miss 0x080.
- Expected: 0x080 replaces the 0x040 line; 0x000 still hits; 0x040 misses.
REQ-045 Flush in IDLE: after 0x100 is resident, pulse flush, then read 0x100.
- Expected: miss, reqAddrI_mem=0x100.
REQ-046 Flush during refill, then read_ready_from_mem.
- Expected: reqI_mem held until ready, no array write, the same address misses again.
REQ-047 Reset mid-refill: assert reset while reqI_mem=1.
- Expected: reqI_mem=0 before the next edge, valid bits clear, a stray read_ready_from_mem is ignored.
REQ-048 Simultaneous flush and read_ready_from_mem in REFILL.
- Expected: IDLE, line not installed.
